// File: rtl/cam_capture.sv
// cam_capture: oversamples a DVP camera bus and assembles RGB565 pixels with x/y and frame markers.
// Optional frame counter: define CAP_STATS_EN to enable frame_cnt (otherwise tied to zero).
`timescale 1ns/1ps
module cam_capture #(
    parameter int CLK_F       = 100_000_000,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int SKIP_FRAMES = 2,
    localparam int XW = $clog2(H_ACTIVE),
    localparam int YW = $clog2(V_ACTIVE)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          cam_init_done,
    input  logic          cam_pclk,
    input  logic          cam_vsync,
    input  logic          cam_href,
    input  logic [7:0]    cam_data,
    output logic          pix_valid,
    output logic [15:0]   pix_data,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic          frame_start,
    output logic          frame_done,
    output logic          line_err,
    output logic [15:0]   frame_cnt
);
    localparam int             SKW       = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;
    localparam logic [SKW-1:0] SKIP_LOAD = SKW'(SKIP_FRAMES);
    localparam logic [SKW-1:0] SKIP_ONE  = SKW'(1);
    localparam logic [XW:0]    X_LIM     = (XW + 1)'(H_ACTIVE);
    localparam logic [YW:0]    Y_LIM     = (YW + 1)'(V_ACTIVE);
    localparam logic [XW:0]    X_ONE     = (XW + 1)'(1);
    localparam logic [YW:0]    Y_ONE     = (YW + 1)'(1);
    localparam int             PCLK_B    = 2;
    localparam int             VS_B      = 1;
    localparam int             HREF_B    = 0;

    typedef enum logic [1:0] {IDLE, SYNC, CAPTURE} state_t;

    typedef struct packed {
        logic       pclk_rise;
        logic       href;
        logic       vs_rise;
        logic       href_fall;
        logic [7:0] data;
    } evt_t;

    logic [2:0][2:0] ctl_s_q, ctl_s_d;
    logic [1:0][7:0] dat_s_q, dat_s_d;
    evt_t [1:0]      evt_q, evt_d;
    evt_t            evt_now, ev;

    state_t          state_q, state_d;
    logic [SKW-1:0]  skip_q, skip_d;
    logic [XW:0]     x_q, x_d;
    logic [YW:0]     y_q, y_d;
    logic            phase_q, phase_d;
    logic [7:0]      hi_q, hi_d;
    logic            start_pend_q, start_pend_d;
    logic            pix_valid_q, pix_valid_d;
    logic [15:0]     pix_data_q, pix_data_d;
    logic [XW-1:0]   pix_x_q, pix_x_d;
    logic [YW-1:0]   pix_y_q, pix_y_d;
    logic            frame_start_q, frame_start_d;
    logic            frame_done_q, frame_done_d;
    logic            line_err_q, line_err_d;

    // Two synchroniser stages plus one history stage; events come from stages 1 and 2.
    always_comb begin
        ctl_s_d = {ctl_s_q[1:0], {cam_pclk, cam_vsync, cam_href}};
        dat_s_d = {dat_s_q[0], cam_data};

        evt_now.pclk_rise = ctl_s_q[1][PCLK_B] & ~ctl_s_q[2][PCLK_B];
        evt_now.vs_rise   = ctl_s_q[1][VS_B] & ~ctl_s_q[2][VS_B];
        evt_now.href_fall = ~ctl_s_q[1][HREF_B] & ctl_s_q[2][HREF_B];
        evt_now.href      = ctl_s_q[1][HREF_B];
        evt_now.data      = dat_s_q[1];

        // Two event stages set the pclk-to-pix_valid latency to four clocks.
        evt_d = {evt_q[0], evt_now};
    end

    assign ev = evt_q[1];

    always_comb begin
        state_d       = state_q;
        skip_d        = skip_q;
        x_d           = x_q;
        y_d           = y_q;
        phase_d       = phase_q;
        hi_d          = hi_q;
        start_pend_d  = 1'b0;
        pix_valid_d   = 1'b0;
        pix_data_d    = pix_data_q;
        pix_x_d       = pix_x_q;
        pix_y_d       = pix_y_q;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;
        line_err_d    = line_err_q;

        if (!cam_init_done) begin
            state_d = IDLE;
            x_d     = '0;
            y_d     = '0;
            phase_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d    = SYNC;
                    skip_d     = SKIP_LOAD;
                    line_err_d = 1'b0;
                    x_d        = '0;
                    y_d        = '0;
                    phase_d    = 1'b0;
                end
                SYNC: begin
                    if (ev.vs_rise) begin
                        if (skip_q == '0) begin
                            frame_start_d = 1'b1;
                            state_d       = CAPTURE;
                            x_d           = '0;
                            y_d           = '0;
                            phase_d       = 1'b0;
                        end else begin
                            skip_d = skip_q - SKIP_ONE;
                        end
                    end
                end
                CAPTURE: begin
                    frame_start_d = start_pend_q;
                    // vsync beats a coincident href fall so the new frame never sees a y step.
                    if (ev.vs_rise) begin
                        frame_done_d = 1'b1;
                        start_pend_d = 1'b1;
                        x_d          = '0;
                        y_d          = '0;
                        phase_d      = 1'b0;
                    end else if (ev.href_fall) begin
                        if (phase_q) line_err_d = 1'b1;
                        if (x_q != '0 && y_q != '1) y_d = y_q + Y_ONE;
                        x_d     = '0;
                        phase_d = 1'b0;
                    end else if (ev.pclk_rise && ev.href) begin
                        if (!phase_q) begin
                            hi_d    = ev.data;
                            phase_d = 1'b1;
                        end else begin
                            phase_d = 1'b0;
                            if (x_q < X_LIM && y_q < Y_LIM) begin
                                pix_valid_d = 1'b1;
                                pix_data_d  = {hi_q, ev.data};
                                pix_x_d     = x_q[XW-1:0];
                                pix_y_d     = y_q[YW-1:0];
                            end else begin
                                line_err_d = 1'b1;
                            end
                            if (x_q != '1) x_d = x_q + X_ONE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ctl_s_q       <= '0;
            dat_s_q       <= '0;
            evt_q         <= '0;
            state_q       <= IDLE;
            skip_q        <= '0;
            x_q           <= '0;
            y_q           <= '0;
            phase_q       <= 1'b0;
            hi_q          <= '0;
            start_pend_q  <= 1'b0;
            pix_valid_q   <= 1'b0;
            pix_data_q    <= '0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            line_err_q    <= 1'b0;
        end else begin
            ctl_s_q       <= ctl_s_d;
            dat_s_q       <= dat_s_d;
            evt_q         <= evt_d;
            state_q       <= state_d;
            skip_q        <= skip_d;
            x_q           <= x_d;
            y_q           <= y_d;
            phase_q       <= phase_d;
            hi_q          <= hi_d;
            start_pend_q  <= start_pend_d;
            pix_valid_q   <= pix_valid_d;
            pix_data_q    <= pix_data_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            line_err_q    <= line_err_d;
        end
    end

    assign pix_valid   = pix_valid_q;
    assign pix_data    = pix_data_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;
    assign line_err    = line_err_q;

`ifdef CAP_STATS_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (frame_done_d) frame_cnt_d = frame_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) frame_cnt_q <= '0;
        else       frame_cnt_q <= frame_cnt_d;
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = 16'd0;
`endif

    // The oversampling scheme is meaningless without a positive system clock rate.
    assert property (@(posedge clk) disable iff (!rstn) (CLK_F > 0));

endmodule

// File: tb/tb_cam_capture.sv
// tb_cam_capture: randomized DVP stimulus against a line/frame-level reference model of cam_capture.
`timescale 1ns/1ps
module tb_cam_capture;
    localparam int H_ACTIVE    = 8;
    localparam int V_ACTIVE    = 4;
    localparam int SKIP_FRAMES = 2;
    localparam int XW          = $clog2(H_ACTIVE);
    localparam int YW          = $clog2(V_ACTIVE);
    localparam int PW          = 16 + XW + YW;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          cam_init_done = 1'b0;
    logic          cam_pclk = 1'b0;
    logic          cam_vsync = 1'b0;
    logic          cam_href = 1'b0;
    logic [7:0]    cam_data = 8'h00;
    logic          pix_valid;
    logic [15:0]   pix_data;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;
    logic          frame_start;
    logic          frame_done;
    logic          line_err;
    logic [15:0]   frame_cnt;

    always #5 clk = ~clk;

    cam_capture #(
        .CLK_F      (100_000_000),
        .H_ACTIVE   (H_ACTIVE),
        .V_ACTIVE   (V_ACTIVE),
        .SKIP_FRAMES(SKIP_FRAMES)
    ) u_dut (
        .clk          (clk),
        .rstn         (rstn),
        .cam_init_done(cam_init_done),
        .cam_pclk     (cam_pclk),
        .cam_vsync    (cam_vsync),
        .cam_href     (cam_href),
        .cam_data     (cam_data),
        .pix_valid    (pix_valid),
        .pix_data     (pix_data),
        .pix_x        (pix_x),
        .pix_y        (pix_y),
        .frame_start  (frame_start),
        .frame_done   (frame_done),
        .line_err     (line_err),
        .frame_cnt    (frame_cnt)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    longint      cyc      = 0;
    logic [PW-1:0] obs_q[$];
    logic [PW-1:0] exp_q[$];
    int          obs_start, obs_done;
    longint      last_start_cyc, last_done_cyc;

    // Reference model state: frames, skip budget and line index, never the DUT's encoding.
    bit          m_init, m_cap, m_err;
    int          m_skip, m_y, exp_start, exp_done, m_frames;
    logic [7:0]  line_bytes[$];

    always @(posedge clk) begin
        cyc++;
        #1;
        if (pix_valid === 1'b1) obs_q.push_back({pix_data, pix_x, pix_y});
        if (frame_start === 1'b1) begin obs_start++; last_start_cyc = cyc; end
        if (frame_done === 1'b1) begin obs_done++; last_done_cyc = cyc; end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] exp_frame_cnt();
`ifdef CAP_STATS_EN
        return 16'(m_frames);
`else
        return 16'd0;
`endif
    endfunction

    task automatic clear_obs();
        obs_q.delete();
        exp_q.delete();
        obs_start = 0; obs_done = 0; exp_start = 0; exp_done = 0;
    endtask

    task automatic model_reset();
        m_cap = 0; m_err = 0; m_skip = SKIP_FRAMES; m_y = 0; m_frames = 0;
    endtask

    task automatic model_init(input bit v);
        if (v && !m_init) begin m_skip = SKIP_FRAMES; m_err = 0; m_cap = 0; end
        if (!v) m_cap = 0;
        m_init = v;
    endtask

    task automatic model_vsync();
        if (!m_init) return;
        if (m_cap) begin exp_done++; exp_start++; m_frames++; m_y = 0; end
        else if (m_skip == 0) begin m_cap = 1; exp_start++; m_y = 0; end
        else m_skip--;
    endtask

    task automatic model_line();
        int npix;
        npix = line_bytes.size() / 2;
        if (!m_cap) return;
        for (int p = 0; p < npix; p++) begin
            if (p < H_ACTIVE && m_y < V_ACTIVE)
                exp_q.push_back({line_bytes[2*p], line_bytes[2*p+1], XW'(p), YW'(m_y)});
            else
                m_err = 1;
        end
        if (line_bytes.size() % 2 != 0) m_err = 1;
        if (npix > 0) m_y++;
    endtask

    task automatic pclk_cycle(input logic [7:0] d, input logic h, input logic v);
        cam_data = d; cam_href = h; cam_vsync = v; cam_pclk = 1'b0;
        repeat ($urandom_range(3, 2)) @(negedge clk);
        cam_pclk = 1'b1;
        repeat ($urandom_range(3, 2)) @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) pclk_cycle(8'h00, 1'b0, 1'b0);
    endtask

    task automatic drive_line();
        for (int i = 0; i < line_bytes.size(); i++) pclk_cycle(line_bytes[i], 1'b1, 1'b0);
        idle(2);
        model_line();
    endtask

    task automatic rand_line(input int nb);
        line_bytes.delete();
        for (int i = 0; i < nb; i++) line_bytes.push_back(8'($urandom));
        drive_line();
    endtask

    task automatic vsync_pulse();
        pclk_cycle(8'h00, 1'b0, 1'b1);
        pclk_cycle(8'h00, 1'b0, 1'b1);
        idle(2);
        model_vsync();
    endtask

    task automatic set_init(input bit v);
        @(negedge clk);
        cam_init_done = v;
        model_init(v);
        idle(1);
    endtask

    task automatic test_reset();
        clear_obs();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({pix_valid, pix_data, pix_x, pix_y, frame_start, frame_done, line_err, frame_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b required all zero",
                     {pix_valid, pix_data, pix_x, pix_y, frame_start, frame_done, line_err, frame_cnt});
        end
        rstn = 1'b1;
        model_reset();
        vsync_pulse();
        rand_line(8);
        vsync_pulse();
        rand_line(8);
        n_checks++;
        if (obs_q.size() !== 0 || obs_start !== 0) begin
            n_fail++;
            $display("FAIL reset_no_init: got %0d pixels %0d starts required 0", obs_q.size(), obs_start);
        end
    endtask

    task automatic test_skip_frames();
        clear_obs();
        set_init(1'b1);
        for (int f = 0; f < 3; f++) begin
            vsync_pulse();
            for (int l = 0; l < 2; l++) begin
                line_bytes.delete();
                for (int b = 0; b < 4; b++) begin line_bytes.push_back(8'h12); line_bytes.push_back(8'h34); end
                drive_line();
            end
        end
        vsync_pulse();
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL skip_pix_count: got %0d required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL skip_pix[%0d]: got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (obs_done !== exp_done || obs_start !== exp_start) begin
            n_fail++;
            $display("FAIL skip_markers: got done=%0d start=%0d required done=%0d start=%0d",
                     obs_done, obs_start, exp_done, exp_start);
        end
        n_checks++;
        if (last_start_cyc !== last_done_cyc + 1) begin
            n_fail++; $display("FAIL skip_start_after_done: got start cyc %0d required %0d",
                               last_start_cyc, last_done_cyc + 1);
        end
        n_checks++;
        if (frame_cnt !== exp_frame_cnt()) begin
            n_fail++; $display("FAIL skip_frame_cnt: got %0d required %0d", frame_cnt, exp_frame_cnt());
        end
    endtask

    task automatic test_latency();
        logic [7:0] b0, b1;
        clear_obs();
        b0 = 8'($urandom); b1 = 8'($urandom);
        pclk_cycle(b0, 1'b1, 1'b0);
        cam_data = b1; cam_pclk = 1'b0;
        repeat (2) @(negedge clk);
        cam_pclk = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (pix_valid !== (k == 4)) begin
                n_fail++; $display("FAIL latency_edge%0d: got pix_valid=%b required %b", k, pix_valid, (k == 4));
            end
        end
        @(negedge clk);
        idle(2);
        line_bytes.delete(); line_bytes.push_back(b0); line_bytes.push_back(b1);
        model_line();
        n_checks++;
        if (obs_q.size() !== 1 || exp_q.size() !== 1 || obs_q[0] !== exp_q[0]) begin
            n_fail++; $display("FAIL latency_pixel: got %0d pixels first %h required %h",
                               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : '0, exp_q[0]);
        end
    endtask

    task automatic test_odd_line();
        clear_obs();
        vsync_pulse();
        rand_line(9);
        rand_line(4);
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL odd_pix_count: got %0d required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL odd_pix[%0d]: got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (line_err !== m_err) begin
            n_fail++; $display("FAIL odd_line_err: got %b required %b", line_err, m_err);
        end
    endtask

    task automatic test_init_drop();
        clear_obs();
        vsync_pulse();
        rand_line(4);
        set_init(1'b0);
        rand_line(6);
        vsync_pulse();
        rand_line(6);
        n_checks++;
        if (obs_done !== exp_done || obs_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL drop_quiet: got done=%0d pix=%0d required done=%0d pix=%0d",
                               obs_done, obs_q.size(), exp_done, exp_q.size());
        end
        set_init(1'b1);
        n_checks++;
        if (line_err !== m_err) begin
            n_fail++; $display("FAIL drop_err_clear: got %b required %b", line_err, m_err);
        end
        for (int f = 0; f < 3; f++) begin
            vsync_pulse();
            rand_line(4);
        end
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL drop_pix_count: got %0d required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL drop_pix[%0d]: got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (obs_done !== exp_done || obs_start !== exp_start || frame_cnt !== exp_frame_cnt()) begin
            n_fail++; $display("FAIL drop_markers: got done=%0d start=%0d cnt=%0d required %0d %0d %0d",
                               obs_done, obs_start, frame_cnt, exp_done, exp_start, exp_frame_cnt());
        end
    endtask

    task automatic test_overlength();
        clear_obs();
        vsync_pulse();
        rand_line(20);
        n_checks++;
        if (line_err !== m_err) begin
            n_fail++; $display("FAIL long_line_err: got %b required %b", line_err, m_err);
        end
        for (int l = 0; l < 4; l++) rand_line(4);
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL long_pix_count: got %0d required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL long_pix[%0d]: got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        clear_obs();
        set_init(1'b0);
        set_init(1'b1);
        for (int f = 0; f < 8; f++) begin
            vsync_pulse();
            for (int l = 0; l < $urandom_range(5, 1); l++) rand_line($urandom_range(20, 1));
        end
        vsync_pulse();
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL rand_pix_count: got %0d required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL rand_pix[%0d]: got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (line_err !== m_err || obs_done !== exp_done || obs_start !== exp_start || frame_cnt !== exp_frame_cnt()) begin
            n_fail++; $display("FAIL rand_status: got err=%b done=%0d start=%0d cnt=%0d required %b %0d %0d %0d",
                               line_err, obs_done, obs_start, frame_cnt, m_err, exp_done, exp_start, exp_frame_cnt());
        end
    endtask

    task automatic test_reset_midline();
        clear_obs();
        vsync_pulse();
        rand_line(3);
        n_checks++;
        if (line_err !== m_err) begin
            n_fail++; $display("FAIL midrst_err_before: got %b required %b", line_err, m_err);
        end
        pclk_cycle(8'h5a, 1'b1, 1'b0);
        cam_data = 8'ha5; cam_pclk = 1'b0;
        repeat (2) @(negedge clk);
        cam_pclk = 1'b1;
        #3;
        rstn = 1'b0;
        #1;
        n_checks++;
        if ({pix_valid, pix_data, pix_x, pix_y, frame_start, frame_done, line_err, frame_cnt} !== '0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got %b required all zero",
                     {pix_valid, pix_data, pix_x, pix_y, frame_start, frame_done, line_err, frame_cnt});
        end
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        model_reset();
        clear_obs();
        for (int i = 0; i < 4; i++) pclk_cycle(8'($urandom), 1'b1, 1'b0);
        idle(2);
        vsync_pulse();
        rand_line(8);
        n_checks++;
        if (obs_q.size() !== exp_q.size() || obs_start !== exp_start || frame_cnt !== exp_frame_cnt()) begin
            n_fail++; $display("FAIL midrst_quiet: got pix=%0d start=%0d cnt=%0d required %0d %0d %0d",
                               obs_q.size(), obs_start, frame_cnt, exp_q.size(), exp_start, exp_frame_cnt());
        end
    endtask

    initial begin
        m_init = 0;
        model_reset();
        test_reset();
        test_skip_frames();
        test_latency();
        test_odd_line();
        test_init_drop();
        test_overlength();
        test_random();
        test_reset_midline();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
